// File: rtl/s2_mdu_control_pkg.sv
// Shared definitions for the stage-2 control unit.
// Holds the RV32 opcode and func3 encodings, the alu_sel codes, the M-extension funct7
// value, the multiply/divide sequencer state encodings and the ALU func3 decode helper.
package s2_mdu_control_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  // CSR func3 values that select a non-ADD ALU operation
  localparam logic [2:0] FNC3_CSRRW  = 3'b001;
  localparam logic [2:0] FNC3_CSRRWI = 3'b101;

  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  // alu_sel codes
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SLL    = 4'd1;
  localparam logic [3:0] ALU_SLT    = 4'd2;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SRL    = 4'd5;
  localparam logic [3:0] ALU_OR     = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_PASS_A = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd11;
  localparam logic [3:0] ALU_SUB    = 4'd12;
  localparam logic [3:0] ALU_SRA    = 4'd13;
  localparam logic [3:0] ALU_PASS_B = 4'd15;

  // Multiply/divide sequencer states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Arithmetic decode shared by R-type and I-type. Bit 30 only means SUB for R-type,
  // since on I-type it is an immediate bit of ADDI.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic bit30,
                                             input logic rtype);
    logic [3:0] sel;
    case (f3)
      3'b000:  sel = (rtype && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/s2_mdu_control_mdu_seq.sv
// Multiply/divide sequencer (mdu_seq): IDLE/BUSY/DONE FSM with a down-counter that
// stalls stage 2 for the configured MDU latency.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   is_mop_i           stage-2 instruction is an enabled M-op
//   is_div_i           the M-op is DIV/DIVU/REM/REMU
//   div_by_zero_i      rs2 is zero (looked at only in the launch cycle)
//   valid_i, flush_i   stage-2 valid and kill
//   stall_o            hold stages 1 and 2
//   mdu_start_o        one-cycle launch pulse
//   wb_mdu_sel_o       stage-2 result comes from the MDU this cycle
module s2_mdu_control_mdu_seq
  import s2_mdu_control_pkg::*;
#(
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 33,
  parameter bit          EARLY_DIV0 = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic is_mop_i,
  input  logic is_div_i,
  input  logic div_by_zero_i,
  input  logic valid_i,
  input  logic flush_i,
  output logic stall_o,
  output logic mdu_start_o,
  output logic wb_mdu_sel_o
);

  localparam int unsigned MaxLat = max_u(MUL_LAT, DIV_LAT);
  localparam int unsigned CntW   = (MaxLat < 2) ? 1 : $clog2(MaxLat);

  // The launch cycle already counts as one stall cycle, and BUSY exits on cnt==0,
  // so LAT-2 yields exactly LAT stall cycles before DONE.
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 2);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 2);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_o      = 1'b0;
    mdu_start_o  = 1'b0;
    wb_mdu_sel_o = 1'b0;

    case (state_q)
      StIdle: begin
        if (valid_i && is_mop_i) begin
          mdu_start_o = 1'b1;
          stall_o     = 1'b1;
          if (EARLY_DIV0 && is_div_i && div_by_zero_i) begin
            state_d = StDone;
          end else begin
            cnt_d   = is_div_i ? DivLoad : MulLoad;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        // Stall released: the M-op leaves stage 2 on this edge.
        wb_mdu_sel_o = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (flush_i) begin
      stall_o      = 1'b0;
      mdu_start_o  = 1'b0;
      wb_mdu_sel_o = 1'b0;
      state_d      = StIdle;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/s2_mdu_control.sv
// Stage-2 (execute) control unit for the RV32(M) core.
// Decodes instruction_s2 into ALU/operand/branch/store/CSR controls and hands M-ops to
// the multiply/divide sequencer, which stalls the pipeline for the MDU latency.
// Ports:
//   clk, rst (sync, active-low)     clock and reset
//   instruction_s2, valid_s2        stage-2 instruction and its valid
//   flush                           kill stage 2
//   div_by_zero                     forwarded rs2 is zero
//   brun, a_sel, b_sel, alu_sel     execute datapath controls
//   mem_wen, csr_we                 side-effect enables (gated by valid/flush)
//   mdu_op, mdu_start, wb_mdu_sel   MDU controls
//   stall, illegal                  pipeline hold, illegal instruction flag
module s2_mdu_control
  import s2_mdu_control_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          MEXT       = 1'b1,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 33,
  parameter bit          EARLY_DIV0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_s2,
  input  logic        valid_s2,
  input  logic        flush,
  input  logic        div_by_zero,
  output logic        brun,
  output logic        a_sel,
  output logic        b_sel,
  output logic        mem_wen,
  output logic        csr_we,
  output logic [3:0]  alu_sel,
  output logic [2:0]  mdu_op,
  output logic        mdu_start,
  output logic        wb_mdu_sel,
  output logic        stall,
  output logic        illegal
);

  // M decode is only meaningful on a 32-bit datapath.
  localparam bit MExtOn = MEXT && (XLEN == 32);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] funct7;
  logic       m_enc;
  logic       is_mop;
  logic       opc_known;
  logic       live;
  logic       unused_instr_bits;

  assign opcode = instruction_s2[6:0];
  assign func3  = instruction_s2[14:12];
  assign funct7 = instruction_s2[31:25];

  // Register specifiers and rd are consumed by the datapath, not by this decoder.
  assign unused_instr_bits = ^{instruction_s2[24:15], instruction_s2[11:7]};

  assign m_enc  = (opcode == OPC_ARI_RTYPE) && (funct7 == FNC7_MULDIV);
  assign is_mop = m_enc && MExtOn;
  assign live   = valid_s2 && !flush;

  always_comb begin
    alu_sel   = ALU_ADD;
    a_sel     = 1'b0;
    b_sel     = 1'b1;
    opc_known = 1'b1;
    case (opcode)
      OPC_LUI:                         alu_sel = ALU_PASS_B;
      OPC_AUIPC, OPC_JAL, OPC_BRANCH:  a_sel = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_STORE:   alu_sel = ALU_ADD;
      OPC_CSR: begin
        if (func3 == FNC3_CSRRW) begin
          alu_sel = ALU_PASS_A;
        end else if (func3 == FNC3_CSRRWI) begin
          alu_sel = ALU_PASS_B;
        end
      end
      OPC_ARI_ITYPE: alu_sel = alu_from_f3(func3, instruction_s2[30], 1'b0);
      OPC_ARI_RTYPE: begin
        b_sel = 1'b0;
        // M-ops keep the ALU idle on ADD; the MDU produces the result.
        if (!is_mop) begin
          alu_sel = alu_from_f3(func3, instruction_s2[30], 1'b1);
        end
      end
      default: opc_known = 1'b0;
    endcase
  end

  assign brun    = instruction_s2[13];
  assign mem_wen = live && (opcode == OPC_STORE);
  // func3==0 under SYSTEM is ECALL/EBREAK, which writes no CSR.
  assign csr_we  = live && (opcode == OPC_CSR) && (func3 != 3'b000);
  assign mdu_op  = is_mop ? func3 : 3'b000;
  assign illegal = valid_s2 && (!opc_known || (m_enc && !MExtOn));

  s2_mdu_control_mdu_seq #(
    .MUL_LAT    (MUL_LAT),
    .DIV_LAT    (DIV_LAT),
    .EARLY_DIV0 (EARLY_DIV0)
  ) u_mdu_seq (
    .clk_i         (clk),
    .rst_ni        (rst),
    .is_mop_i      (is_mop),
    .is_div_i      (func3[2]),
    .div_by_zero_i (div_by_zero),
    .valid_i       (valid_s2),
    .flush_i       (flush),
    .stall_o       (stall),
    .mdu_start_o   (mdu_start),
    .wb_mdu_sel_o  (wb_mdu_sel)
  );

endmodule

// File: tb/tb_s2_mdu_control.sv
// Bench for s2_mdu_control: three instances (default, EARLY_DIV0=0, MEXT=0) share the
// instruction bus; only the instance selected by sel sees valid_s2.
module tb_s2_mdu_control;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction_s2 = '0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        div_by_zero = 1'b0;
  int          sel = 0;

  logic valid_a, valid_b, valid_c;
  assign valid_a = valid && (sel == 0);
  assign valid_b = valid && (sel == 1);
  assign valid_c = valid && (sel == 2);

  logic       brun_a, a_sel_a, b_sel_a, mem_wen_a, csr_we_a;
  logic [3:0] alu_sel_a;
  logic [2:0] mdu_op_a;
  logic       start_a, wb_a, stall_a, illegal_a;
  logic       start_b, wb_b, stall_b, illegal_b;
  logic       start_c, wb_c, stall_c, illegal_c;
  logic       unused_brun_b, unused_asel_b, unused_bsel_b, unused_mw_b, unused_cw_b;
  logic [3:0] unused_alu_b;
  logic [2:0] unused_op_b;
  logic       unused_brun_c, unused_asel_c, unused_bsel_c, unused_mw_c, unused_cw_c;
  logic [3:0] unused_alu_c;
  logic [2:0] unused_op_c;

  always #5 clk = ~clk;

  s2_mdu_control u_dut (
    .clk (clk), .rst (rst), .instruction_s2 (instruction_s2), .valid_s2 (valid_a),
    .flush (flush), .div_by_zero (div_by_zero), .brun (brun_a), .a_sel (a_sel_a),
    .b_sel (b_sel_a), .mem_wen (mem_wen_a), .csr_we (csr_we_a), .alu_sel (alu_sel_a),
    .mdu_op (mdu_op_a), .mdu_start (start_a), .wb_mdu_sel (wb_a), .stall (stall_a),
    .illegal (illegal_a)
  );

  s2_mdu_control #(.EARLY_DIV0 (1'b0)) u_dut_late (
    .clk (clk), .rst (rst), .instruction_s2 (instruction_s2), .valid_s2 (valid_b),
    .flush (flush), .div_by_zero (div_by_zero), .brun (unused_brun_b),
    .a_sel (unused_asel_b), .b_sel (unused_bsel_b), .mem_wen (unused_mw_b),
    .csr_we (unused_cw_b), .alu_sel (unused_alu_b), .mdu_op (unused_op_b),
    .mdu_start (start_b), .wb_mdu_sel (wb_b), .stall (stall_b), .illegal (illegal_b)
  );

  s2_mdu_control #(.MEXT (1'b0)) u_dut_nom (
    .clk (clk), .rst (rst), .instruction_s2 (instruction_s2), .valid_s2 (valid_c),
    .flush (flush), .div_by_zero (div_by_zero), .brun (unused_brun_c),
    .a_sel (unused_asel_c), .b_sel (unused_bsel_c), .mem_wen (unused_mw_c),
    .csr_we (unused_cw_c), .alu_sel (unused_alu_c), .mdu_op (unused_op_c),
    .mdu_start (start_c), .wb_mdu_sel (wb_c), .stall (stall_c), .illegal (illegal_c)
  );

  logic mon_stall, mon_start, mon_wb, mon_illegal;
  always_comb begin
    case (sel)
      1: begin
        mon_stall = stall_b; mon_start = start_b; mon_wb = wb_b; mon_illegal = illegal_b;
      end
      2: begin
        mon_stall = stall_c; mon_start = start_c; mon_wb = wb_c; mon_illegal = illegal_c;
      end
      default: begin
        mon_stall = stall_a; mon_start = start_a; mon_wb = wb_a; mon_illegal = illegal_a;
      end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string      tag;
    logic [3:0] alu;
    logic       a, b, mw, cw, ill, br;
  } dexp_t;

  typedef struct {
    string      tag;
    int         lat;
    logic [2:0] op;
  } mexp_t;

  dexp_t dq[$];
  mexp_t mq[$];

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd3, 5'd2, f3, 5'd1, op};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one decode-only instruction on instance a and compare its controls.
  task automatic dec(input string tag, input logic [31:0] instr, input logic v,
                     input logic [3:0] alu, input logic a, input logic b, input logic mw,
                     input logic cw, input logic ill, input logic br);
    dexp_t e;
    sel = 0;
    instruction_s2 = instr;
    valid = v;
    dq.push_back('{tag, alu, a, b, mw, cw, ill, br});
    @(negedge clk);
    e = dq.pop_front();
    check_val({e.tag, "_alu"}, 32'(alu_sel_a), 32'(e.alu));
    check_val({e.tag, "_asel"}, 32'(a_sel_a), 32'(e.a));
    check_val({e.tag, "_bsel"}, 32'(b_sel_a), 32'(e.b));
    check_val({e.tag, "_memwen"}, 32'(mem_wen_a), 32'(e.mw));
    check_val({e.tag, "_csrwe"}, 32'(csr_we_a), 32'(e.cw));
    check_val({e.tag, "_illegal"}, 32'(illegal_a), 32'(e.ill));
    check_val({e.tag, "_brun"}, 32'(brun_a), 32'(e.br));
    check_val({e.tag, "_stall"}, 32'(stall_a), 32'd0);
    next_cycle();
    valid = 1'b0;
  endtask

  // Launch an M-op on instance s and follow it until wb_mdu_sel, bounded.
  task automatic run_mop(input string tag, input logic [31:0] instr, input logic dz,
                         input int s, input int lat);
    mexp_t e;
    bit    done;
    sel = s;
    instruction_s2 = instr;
    valid = 1'b1;
    div_by_zero = dz;
    mq.push_back('{tag, lat, instr[14:12]});
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      check_val({tag, "_stall"}, 32'(mon_stall), 32'(k < lat));
      check_val({tag, "_start"}, 32'(mon_start), 32'(k == 0));
      if (k == 0) check_val({tag, "_illegal"}, 32'(mon_illegal), 32'd0);
      if (mon_wb) begin
        e = mq.pop_front();
        check_val({e.tag, "_lat"}, 32'(k), 32'(e.lat));
        if (s == 0) check_val({e.tag, "_mduop"}, 32'(mdu_op_a), 32'(e.op));
        done = 1'b1;
      end
      next_cycle();
      div_by_zero = 1'b0;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    if (!done) mq.delete();
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mul_i, div_i, divu_i;
    mul_i  = enc(7'b0000001, 3'b000, OP_R);
    div_i  = enc(7'b0000001, 3'b100, OP_R);
    divu_i = enc(7'b0000001, 3'b101, OP_R);

    // Reset state, with an M-op on the bus but no valid
    instruction_s2 = mul_i;
    repeat (3) next_cycle();
    @(negedge clk);
    check_val("rst_stall", 32'({stall_a, stall_b, stall_c}), 32'd0);
    check_val("rst_start", 32'({start_a, start_b, start_c}), 32'd0);
    check_val("rst_wb", 32'({wb_a, wb_b, wb_c}), 32'd0);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bubble_mop_stall", 32'(stall_a), 32'd0);
      check_val("bubble_mop_start", 32'(start_a), 32'd0);
      next_cycle();
    end

    // Decode table: tag, instr, valid, alu, a_sel, b_sel, mem_wen, csr_we, illegal, brun
    dec("ADD",   enc(7'b0000000, 3'b000, OP_R), 1, 4'd0,  0, 0, 0, 0, 0, 0);
    dec("SUB",   enc(7'b0100000, 3'b000, OP_R), 1, 4'd12, 0, 0, 0, 0, 0, 0);
    dec("SRA",   enc(7'b0100000, 3'b101, OP_R), 1, 4'd13, 0, 0, 0, 0, 0, 0);
    dec("SLTU",  enc(7'b0000000, 3'b011, OP_R), 1, 4'd11, 0, 0, 0, 0, 0, 1);
    dec("LUI",   enc(7'b0000000, 3'b000, OP_LUI), 1, 4'd15, 0, 1, 0, 0, 0, 0);
    dec("AUIPC", enc(7'b0000000, 3'b010, OP_AUIPC), 1, 4'd0, 1, 1, 0, 0, 0, 1);
    dec("CSRRWI", enc(7'b0011000, 3'b101, OP_CSR), 1, 4'd15, 0, 1, 0, 1, 0, 0);
    dec("CSRRW", enc(7'b0011000, 3'b001, OP_CSR), 1, 4'd8, 0, 1, 0, 1, 0, 0);
    dec("XORI",  enc(7'b0000000, 3'b100, OP_I), 1, 4'd4,  0, 1, 0, 0, 0, 0);
    dec("SRAI",  enc(7'b0100000, 3'b101, OP_I), 1, 4'd13, 0, 1, 0, 0, 0, 0);
    dec("ADDI30", enc(7'b0100000, 3'b000, OP_I), 1, 4'd0, 0, 1, 0, 0, 0, 0);
    dec("BLTU",  enc(7'b0000000, 3'b110, OP_BR), 1, 4'd0, 1, 1, 0, 0, 0, 1);
    dec("SW",    enc(7'b0000000, 3'b010, OP_ST), 1, 4'd0, 0, 1, 1, 0, 0, 1);
    dec("SW_bub", enc(7'b0000000, 3'b010, OP_ST), 0, 4'd0, 0, 1, 0, 0, 0, 1);
    dec("BADOP", enc(7'b0000000, 3'b000, 7'h7f), 1, 4'd0, 0, 1, 0, 0, 1, 0);
    dec("MULHU_bub", enc(7'b0000001, 3'b011, OP_R), 0, 4'd0, 0, 0, 0, 0, 0, 1);

    // Multi-cycle sequencing, including back-to-back launches
    run_mop("MUL", mul_i, 1'b0, 0, 4);
    run_mop("DIV", div_i, 1'b0, 0, 33);
    run_mop("MUL_dz", mul_i, 1'b1, 0, 4);
    run_mop("DIVU_dz_early", divu_i, 1'b1, 0, 1);
    run_mop("DIVU_dz_late", divu_i, 1'b1, 1, 33);

    // Flush in cycle 5 of a DIV; the next cycle must be back in IDLE
    sel = 0;
    instruction_s2 = div_i;
    valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("flush_pre_stall", 32'(stall_a), 32'd1);
      check_val("flush_pre_wb", 32'(wb_a), 32'd0);
      next_cycle();
    end
    flush = 1'b1;
    @(negedge clk);
    check_val("flush_stall", 32'(stall_a), 32'd0);
    check_val("flush_start", 32'(start_a), 32'd0);
    check_val("flush_wb", 32'(wb_a), 32'd0);
    check_val("flush_memwen", 32'(mem_wen_a), 32'd0);
    next_cycle();
    flush = 1'b0;
    run_mop("MUL_after_flush", mul_i, 1'b0, 0, 4);

    // Reset during BUSY
    sel = 0;
    instruction_s2 = mul_i;
    valid = 1'b1;
    @(negedge clk);
    check_val("rstbusy_launch", 32'(start_a), 32'd1);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check_val("rstbusy_during", 32'(stall_a), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_val("rstbusy_stall", 32'(stall_a), 32'd0);
    check_val("rstbusy_wb", 32'(wb_a), 32'd0);
    check_val("rstbusy_start", 32'(start_a), 32'd0);
    next_cycle();
    run_mop("MUL_after_rst", mul_i, 1'b0, 0, 4);

    // MEXT=0 instance: M encoding is illegal and never starts the MDU
    sel = 2;
    instruction_s2 = mul_i;
    valid = 1'b1;
    @(negedge clk);
    check_val("nom_illegal", 32'(illegal_c), 32'd1);
    check_val("nom_stall", 32'(stall_c), 32'd0);
    check_val("nom_start", 32'(start_c), 32'd0);
    next_cycle();
    @(negedge clk);
    check_val("nom_stall2", 32'(stall_c), 32'd0);
    next_cycle();
    valid = 1'b0;

    check_val("sb_empty", 32'(mq.size() + dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s2_mdu_control.md
# s2_mdu_control

Stage-2 (execute) control unit for the three-stage RV32 core, extended to RV32M. It decodes the instruction held in stage 2 into ALU, operand-select, branch and store/CSR controls. It also sequences multi-cycle multiply/divide operations with a counter-driven FSM that stalls the pipeline for a parametrised latency. It replaces the purely combinational stage-2 decoder and sits between the stage-1/2 pipeline register and the execute datapath and MDU.

## Interface
- `XLEN`, 32: datapath width; only affects `mdu_op` decode legality checks (fixed 32 for RV32).
- `MEXT`, 1: 1 enables RV32M decode; 0 flags M-encodings as illegal.
- `MUL_LAT`, 4: cycles from `mdu_start` to result for MUL/MULH/MULHSU/MULHU; legal range 2..16.
- `DIV_LAT`, 33: cycles for DIV/DIVU/REM/REMU; legal range 2..64.
- `EARLY_DIV0`, 1: 1 completes divide-by-zero in one cycle.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-low (`rst`=0 resets on the `clk` edge).
- `instruction_s2` in 32: instruction in stage 2.
- `valid_s2` in 1: stage 2 holds a real instruction (0 = bubble).
- `flush` in 1: kill stage 2 (branch/jump redirect).
- `div_by_zero` in 1: rs2 operand of stage 2 is zero (forwarded value).
- `brun` out 1: unsigned branch compare (`instruction_s2[13]`).
- `a_sel` out 1: 1 = PC for AUIPC/JAL/BRANCH.
- `b_sel` out 1: 0 = rs2 for R-type, else immediate.
- `mem_wen` out 1: store.
- `csr_we` out 1: CSR write, gated by `valid_s2`.
- `alu_sel` out 4: ALU operation.
- `mdu_op` out 3: func3 of the M instruction.
- `mdu_start` out 1: one-cycle launch pulse to the MDU.
- `wb_mdu_sel` out 1: stage-2 result comes from the MDU this cycle.
- `stall` out 1: hold stages 1 and 2.
- `illegal` out 1: unrecognised opcode, or an M-op with `MEXT`=0, while `valid_s2`.

## Operation
- **alu_sel codes:** ADD 0, SLL 1, SLT 2, XOR 4, SRL 5, OR 6, AND 7, PASS_A 8, SLTU 11, SUB 12, SRA 13, PASS_B 15.
- **Opcode mapping:**
  - LUI → 15.
  - AUIPC, JAL, JALR, BRANCH, LOAD, STORE → 0.
  - CSRRW → 8; CSRRWI → 15; other CSR func3 → 0.
  - R-type and I-type decode by func3. Bit 30 selects SUB (R-type only) and SRA (both).
- **M-op:** opcode ARI_RTYPE with funct7=0000001.
  - `alu_sel`=0 and `mdu_op`=func3.
  - The ALU decode for M-ops is suppressed.
- **Gating:** `mem_wen`, `csr_we` and `mdu_start` are 0 when `valid_s2`=0 or `flush`=1.
- **FSM states:** IDLE, BUSY, DONE. Down-counter `cnt`, width $clog2(max(MUL_LAT,DIV_LAT)).
  - IDLE, with a valid unflushed M-op:
    - `mdu_start`=1, `stall`=1.
    - If the op is a divide with `EARLY_DIV0`=1 and `div_by_zero`=1, go to DONE.
    - Otherwise load `cnt`=LAT-2 and go to BUSY.
  - BUSY: `stall`=1. Decrement `cnt`; go to DONE when `cnt`=0.
  - DONE: `stall`=0, `wb_mdu_sel`=1. The instruction leaves stage 2 at this clock edge; go to IDLE.
- **Flush:** `flush`=1 in any state forces `stall`=0, `mdu_start`=0 and `wb_mdu_sel`=0 combinationally. Next state is IDLE and `cnt` is cleared.
- **`div_by_zero`:** sampled only in the IDLE launch cycle.

## Timing
- **Reset:** state IDLE, `cnt`=0. `stall`, `mdu_start` and `wb_mdu_sel` are 0. Decode outputs are combinational from `instruction_s2`.
- **Reset mid-operation:** aborts the sequence. Outputs return to reset values on the next cycle.
- **Non-M instructions:** zero added latency, `stall`=0.
- **M-op launched in cycle 0:**
  - `stall` is high for cycles 0..LAT-1.
  - DONE is in cycle LAT.
  - Total residency in stage 2 is LAT+1 cycles.
- **Early divide-by-zero:** stall in cycle 0 only; DONE in cycle 1.
- **Back-to-back M-ops:** the second op launches in the cycle after DONE; there is no overlap.
- **Invalid input in IDLE:** `valid_s2`=0 never leaves IDLE.

## Structure
- Opcode and func3 defines come from the existing shared opcode header.
- A shared package/header adds:
  - the `ALU_*` alu_sel localparams;
  - `FNC7_MULDIV`=7'b0000001;
  - the FSM state encodings.
- One sub-module, `mdu_seq`, holds the FSM and counter. Its inputs are `is_mop`, `is_div`, `div_by_zero`, `valid` and `flush`. Its outputs are `stall`, `mdu_start` and `wb_mdu_sel`.
- The top level is the decode logic.

## Test plan
- ADD/SUB/SRA/SLTU/LUI/AUIPC/CSRRWI with `valid_s2`=1 → `alu_sel` is 0/12/13/11/15/0/15 respectively, `stall`=0, `a_sel`/`b_sel` correct.
- MUL (funct7=1, func3=0) with `MUL_LAT`=4 → `mdu_start` high in cycle 0 only, `stall` high in cycles 0-3, `wb_mdu_sel` high in cycle 4, `mdu_op`=0.
- DIVU with `div_by_zero`=1:
  - `EARLY_DIV0`=1 → stall 1 cycle, DONE in cycle 1.
  - `EARLY_DIV0`=0 → stall 33 cycles.
- DIV launched, then `flush` asserted in cycle 5 → `stall` drops in cycle 5, IDLE in cycle 6, no `wb_mdu_sel`.
- `rst`=0 asserted during BUSY → outputs 0 on the next cycle; a subsequent MUL takes the full latency.
- `MEXT`=0 with a MUL encoding → `illegal`=1, `stall`=0, `mdu_start`=0. A bubble (`valid_s2`=0) with a STORE encoding → `mem_wen`=0.
